// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the MIPS instruction-fetch stage: FSM encoding,
// the reset/misalign instruction value and the timeout counter sizing helper.
package mips_fetch_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

    function automatic int tmo_ctr_w(input int cyc);
        return $clog2(cyc + 1);
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory read bus: request/address out, acknowledge/data back.
interface inst_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/inst_fetch_unit_timeout_ctr.sv
// BUSY-cycle counter; expired is high during the TIMEOUT_CYC-th consecutive
// enabled cycle after a clear.
module fetch_timeout_ctr
    import mips_fetch_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = tmo_ctr_w(TIMEOUT_CYC);

    logic [W-1:0] r_cnt;

    assign expired = enable && (r_cnt == W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (clear)
            r_cnt <= '0;
        else if (enable && !expired)
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: one outstanding read at a time, flush-drop of
// in-flight data. Optional bus timeout abort when FETCH_TIMEOUT_EN is defined.
module inst_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    pc_in,
    input  logic                 fetch_req,
    input  logic                 flush,
    inst_fetch_unit_if.master    bus,
    output logic [DATA_W-1:0]    instr,
    output logic                 instr_valid,
    output logic                 stall,
    output logic                 misalign_err,
    output logic                 timeout_err
);
    logic [0:0]        r_state;
    logic              r_drop;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_instr;
    logic              r_instr_valid;
    logic              r_misalign;
    logic              r_timeout;

    logic w_aligned;
    logic w_accept;
    logic w_busy;
    logic w_expired;

    assign w_aligned = (pc_in[1:0] == 2'b00);
    assign w_busy    = (r_state == ST_BUSY);
    assign w_accept  = !w_busy && fetch_req && w_aligned;
    assign stall     = w_busy || w_accept;

`ifdef FETCH_TIMEOUT_EN
    logic w_tmo_pulse;

    fetch_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_accept),
        .enable  (w_busy),
        .expired (w_expired)
    );
    assign w_tmo_pulse = r_timeout;
    assign timeout_err = w_tmo_pulse;
`else
    logic w_unused_tmo;

    assign w_unused_tmo = ^TIMEOUT_CYC;
    assign w_expired    = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_drop        <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_instr       <= DATA_W'(MIPS_NOP);
            r_instr_valid <= 1'b0;
            r_misalign    <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_instr_valid <= 1'b0;
            r_misalign    <= 1'b0;
            r_timeout     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (fetch_req) begin
                        if (w_aligned) begin
                            r_mem_addr <= pc_in;
                            r_mem_req  <= 1'b1;
                            r_drop     <= 1'b0;
                            r_state    <= ST_BUSY;
                        end else begin
                            r_misalign <= 1'b1;
                            r_instr    <= DATA_W'(MIPS_NOP);
                        end
                    end
                end
                ST_BUSY: begin
                    if (bus.mem_ack) begin
                        // A flush arriving with the ack still kills this word.
                        if (!(r_drop || flush)) begin
                            r_instr       <= bus.mem_rdata;
                            r_instr_valid <= 1'b1;
                        end
                        r_mem_req <= 1'b0;
                        r_drop    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (w_expired) begin
                        r_mem_req <= 1'b0;
                        r_timeout <= 1'b1;
                        r_drop    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (flush) begin
                        r_drop <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.mem_req  = r_mem_req;
    assign bus.mem_addr = r_mem_addr;
    assign instr        = r_instr;
    assign instr_valid  = r_instr_valid;
    assign misalign_err = r_misalign;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed table, hand sequences for
// long waits / reset mid-fetch / timeout (FETCH_TIMEOUT_EN), and random traffic.
module tb_inst_fetch_unit;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc_in;
    logic          fetch_req;
    logic          flush;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic          stall;
    logic          misalign_err;
    logic          timeout_err;

    always #5 clk = ~clk;

    inst_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    inst_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_in        (pc_in),
        .fetch_req    (fetch_req),
        .flush        (flush),
        .bus          (bus),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .stall        (stall),
        .misalign_err (misalign_err),
        .timeout_err  (timeout_err)
    );

    typedef struct packed {
        logic          req;
        logic [AW-1:0] addr;
        logic [DW-1:0] ins;
        logic          vld;
        logic          stl;
        logic          mis;
        logic          tmo;
    } obs_t;

    typedef struct {
        logic          fr;
        logic          fl;
        logic [AW-1:0] pc;
        logic          ack;
        logic [DW-1:0] rd;
        obs_t          exp;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int vcnt  = 0;
    int tcnt  = 0;

    // Transaction-level reference: one outstanding fetch, a kill flag, age.
    logic          m_busy, m_drop, m_valid, m_mis, m_tmo;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_instr;
    int            m_age;

    task automatic mdl_reset();
        m_busy = 0; m_drop = 0; m_valid = 0; m_mis = 0; m_tmo = 0;
        m_addr = '0; m_instr = '0; m_age = 0;
    endtask

    function automatic obs_t predict(input logic fr, input logic [AW-1:0] pc);
        obs_t o;
        o.req  = m_busy;
        o.addr = m_addr;
        o.ins  = m_instr;
        o.vld  = m_valid;
        o.stl  = m_busy || (fr && pc[1:0] == 2'b00);
        o.mis  = m_mis;
        o.tmo  = m_tmo;
        return o;
    endfunction

    task automatic mdl_update(input logic fr, input logic fl, input logic [AW-1:0] pc,
                              input logic ack, input logic [DW-1:0] rd);
        m_valid = 0; m_mis = 0; m_tmo = 0;
        if (m_busy) begin
            if (ack) begin
                if (!(m_drop || fl)) begin
                    m_instr = rd;
                    m_valid = 1;
                end
                m_busy = 0; m_drop = 0;
            end else begin
`ifdef FETCH_TIMEOUT_EN
                if (m_age == TMO - 1) begin
                    m_busy = 0; m_drop = 0; m_tmo = 1;
                end else begin
                    m_age = m_age + 1;
                    if (fl) m_drop = 1;
                end
`else
                if (fl) m_drop = 1;
`endif
            end
        end else if (fr) begin
            if (pc[1:0] == 2'b00) begin
                m_busy = 1; m_addr = pc; m_drop = 0; m_age = 0;
            end else begin
                m_mis = 1; m_instr = '0;
            end
        end
    endtask

    function automatic obs_t observe();
        obs_t o;
        o.req  = bus.mem_req;
        o.addr = bus.mem_addr;
        o.ins  = instr;
        o.vld  = instr_valid;
        o.stl  = stall;
        o.mis  = misalign_err;
        o.tmo  = timeout_err;
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got req=%0b addr=%h instr=%h vld=%0b stall=%0b mis=%0b tmo=%0b, expected req=%0b addr=%h instr=%h vld=%0b stall=%0b mis=%0b tmo=%0b",
                     name, got.req, got.addr, got.ins, got.vld, got.stl, got.mis, got.tmo,
                     exp.req, exp.addr, exp.ins, exp.vld, exp.stl, exp.mis, exp.tmo);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(input logic fr, input logic fl, input logic [AW-1:0] pc,
                         input logic ack, input logic [DW-1:0] rd);
        fetch_req = fr; flush = fl; pc_in = pc; bus.mem_ack = ack; bus.mem_rdata = rd;
    endtask

    // Entered at posedge+1; drives, checks at posedge+4, leaves at next posedge+1.
    task automatic step(input string name, input logic fr, input logic fl,
                        input logic [AW-1:0] pc, input logic ack, input logic [DW-1:0] rd);
        obs_t g;
        drive(fr, fl, pc, ack, rd);
        #3;
        g = observe();
        check(name, g, predict(fr, pc));
        if (g.vld) vcnt++;
        if (g.tmo) tcnt++;
        mdl_update(fr, fl, pc, ack, rd);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        drive(0, 0, '0, 0, '0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        mdl_reset();
    endtask

    function automatic vec_t mkv(input logic fr, input logic fl, input logic [AW-1:0] pc,
                                 input logic ack, input logic [DW-1:0] rd,
                                 input logic req, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] ins, input logic vld,
                                 input logic stl, input logic mis);
        vec_t v;
        v.fr = fr; v.fl = fl; v.pc = pc; v.ack = ack; v.rd = rd;
        v.exp.req = req; v.exp.addr = addr; v.exp.ins = ins;
        v.exp.vld = vld; v.exp.stl = stl; v.exp.mis = mis; v.exp.tmo = 1'b0;
        return v;
    endfunction

    vec_t tbl[16];

    initial begin
        obs_t g;
        reset = 1'b0;
        drive(0, 0, '0, 0, '0);
        #1;
        do_reset();
        #3;
        check("reset_state", observe(), obs_t'('0));
        @(posedge clk); #1;

        //          fr fl pc            ack rdata         | req addr          instr         vld stl mis
        tbl[0]  = mkv(1, 0, 32'h0040_0000, 0, 32'h0,        0, 32'h0,         32'h0,         0, 1, 0);
        tbl[1]  = mkv(0, 0, 32'h0,         1, 32'h2008_0005, 1, 32'h0040_0000, 32'h0,         0, 1, 0);
        tbl[2]  = mkv(0, 0, 32'h0,         0, 32'h0,        0, 32'h0040_0000, 32'h2008_0005, 1, 0, 0);
        tbl[3]  = mkv(1, 0, 32'h0040_0004, 0, 32'h0,        0, 32'h0040_0000, 32'h2008_0005, 0, 1, 0);
        tbl[4]  = mkv(0, 0, 32'h0,         0, 32'h0,        1, 32'h0040_0004, 32'h2008_0005, 0, 1, 0);
        tbl[5]  = mkv(1, 1, 32'h0040_0020, 0, 32'h0,        1, 32'h0040_0004, 32'h2008_0005, 0, 1, 0);
        tbl[6]  = mkv(0, 0, 32'h0,         1, 32'hDEAD_BEEF, 1, 32'h0040_0004, 32'h2008_0005, 0, 1, 0);
        tbl[7]  = mkv(0, 0, 32'h0,         0, 32'h0,        0, 32'h0040_0004, 32'h2008_0005, 0, 0, 0);
        tbl[8]  = mkv(1, 0, 32'h0040_0008, 0, 32'h0,        0, 32'h0040_0004, 32'h2008_0005, 0, 1, 0);
        tbl[9]  = mkv(0, 0, 32'h0,         1, 32'h1111_2222, 1, 32'h0040_0008, 32'h2008_0005, 0, 1, 0);
        tbl[10] = mkv(1, 0, 32'h0040_0002, 0, 32'h0,        0, 32'h0040_0008, 32'h1111_2222, 1, 0, 0);
        tbl[11] = mkv(0, 0, 32'h0,         0, 32'h0,        0, 32'h0040_0008, 32'h0,         0, 0, 1);
        tbl[12] = mkv(1, 1, 32'h0040_0010, 0, 32'h0,        0, 32'h0040_0008, 32'h0,         0, 1, 0);
        tbl[13] = mkv(0, 1, 32'h0,         1, 32'h3333_4444, 1, 32'h0040_0010, 32'h0,         0, 1, 0);
        tbl[14] = mkv(0, 0, 32'h0,         1, 32'h0000_0055, 0, 32'h0040_0010, 32'h0,         0, 0, 0);
        tbl[15] = mkv(0, 0, 32'h0,         0, 32'h0,        0, 32'h0040_0010, 32'h0,         0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].fr, tbl[i].fl, tbl[i].pc, tbl[i].ack, tbl[i].rd);
            #3;
            g = observe();
            check($sformatf("vec%0d", i), g, tbl[i].exp);
            mdl_update(tbl[i].fr, tbl[i].fl, tbl[i].pc, tbl[i].ack, tbl[i].rd);
            @(posedge clk); #1;
        end

        // Slow memory: five wait cycles, exactly one valid pulse.
        vcnt = 0;
        step("slow_req", 1, 0, 32'h0040_0100, 0, '0);
        for (int i = 0; i < 5; i++) step("slow_wait", 0, 0, '0, 0, '0);
        step("slow_ack", 0, 0, '0, 1, 32'hA5A5_0001);
        step("slow_done", 0, 0, '0, 0, '0);
        step("slow_idle", 0, 0, '0, 0, '0);
        check_int("slow_valid_pulses", vcnt, 1);

        // Reset mid-BUSY: bus request must fall without a clock edge.
        step("rst_req", 1, 0, 32'h0040_0200, 0, '0);
        step("rst_busy", 0, 0, '0, 0, '0);
        #2 reset = 1'b1;
        #1;
        check("rst_async", observe(), obs_t'('0));
        @(posedge clk); #1 reset = 1'b0;
        mdl_reset();
        vcnt = 0;
        step("rst_late_ack", 0, 0, '0, 1, 32'hBAD0_BAD0);
        step("rst_after", 0, 0, '0, 0, '0);
        check_int("rst_no_valid", vcnt, 0);

`ifdef FETCH_TIMEOUT_EN
        tcnt = 0;
        step("tmo_req", 1, 0, 32'h0040_0300, 0, '0);
        for (int i = 0; i < TMO; i++) step("tmo_wait", 0, 0, '0, 0, '0);
        step("tmo_after", 0, 0, '0, 0, '0);
        check_int("tmo_pulses", tcnt, 1);
`endif

        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] pc;
            pc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) pc[1:0] = 2'($urandom_range(1, 3));
            step("random", 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), pc,
                 ($urandom_range(0, 2) == 0), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
